alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
// Instruction-side driver for the ALU: accepts one instruction at a time over a valid/ready
// handshake, reads operands from an internal register file, drives the ALU operand/opcode inputs,
// captures the ALU result and writes it back. Sits between the fetch/decode stage and the ALU.
// PARAMETERS
// DATA_W   32  operand/result width; must match the ALU width
// NREGS    8   register-file entries; r0 reads as zero
// REG_AW   3   register address width; NREGS == 2**REG_AW
// PORTS
// clk          in   1       clock, rising edge
// rst_n        in   1       asynchronous active-low reset
// instr_valid  in   1       instruction offered
// instr_ready  out  1       unit can accept; transfer when valid & ready
// instr_op     in   4       ALU opcode (encoding below)
// instr_rd     in   REG_AW  destination register
// instr_ra     in   REG_AW  source register A
// instr_rb     in   REG_AW  source register B
// alu_a        out  DATA_W  ALU input_a
// alu_b        out  DATA_W  ALU input_b
// alu_op       out  4       ALU opcode
// alu_res      in   DATA_W  ALU result (combinational from alu_a/alu_b/alu_op)
// wb_valid     out  1       one-cycle pulse: register write happening this cycle
// wb_rd        out  REG_AW  register written
// wb_data      out  DATA_W  value written
// illegal_op   out  1       sticky: an unsupported opcode was accepted
// dbg_addr     in   REG_AW  debug read address
// dbg_data     out  DATA_W  combinational read of regs[dbg_addr]; 0 for r0
// BEHAVIOUR
// - Opcodes: 0000 nop, 0010 inc, 0011 dec, 0100 add, 0101 sub, 1000 or, 1001 and, 1010 xor,
//   1011 not. All other values are illegal.
// - FSM: IDLE -> EXEC -> WB -> IDLE. instr_ready = 1 only in IDLE (one instr per 3 cycles).
// - IDLE: on valid & ready, latch op/rd/ra/rb. Legal non-nop op -> EXEC. nop -> stay IDLE, no
//   write. Illegal op -> stay IDLE, no write, set illegal_op.
// - EXEC: alu_a = regs[ra], alu_b = regs[rb] (r0 reads 0), alu_op = latched op; alu_res is
//   registered at the end of this cycle -> WB.
// - WB: wb_valid = 1, wb_rd = rd, wb_data = captured result; regs[rd] written at the end of the
//   cycle (write to r0 is discarded, but wb_valid still pulses) -> IDLE.
// - Outside EXEC: alu_op = 0000, alu_a = alu_b = 0. Outside WB: wb_valid = 0, wb_rd = 0, wb_data = 0.
// - Latency: accepted at edge N -> wb_valid high in the cycle after edge N+1 -> result visible
//   on dbg_data after edge N+2. A read-after-write in the next instruction gets the new value.
// - Arithmetic wraps modulo 2**DATA_W (ALU carry-out ignored). ra == rb == rd is legal.
// - Reset (async, any state): FSM = IDLE, all regs = 0, illegal_op = 0, instr_ready = 1,
//   wb_valid = 0, alu_* = 0. An in-flight instruction is dropped and never written back.
// - illegal_op clears only on reset.
// TESTING
// - Reset, then dbg_addr sweep 0..7 -> dbg_data = 0 for all; instr_ready = 1, illegal_op = 0.
// - inc r1<-r1 x3, then add r2<-r1,r1 -> r1 = 3, r2 = 6; wb_valid pulses 4x, ready low 2 cyc each.
// - r1 = 0 (reset), dec r3<-r3, sub r4<-r0,r1 -> r3 = 0xFFFFFFFF, r4 = 0; not r5<-r0 -> 0xFFFFFFFF.
// - or/and/xor with r1 = 0x0F0F0F0F, r2 = 0x00FF00FF -> 0x0FFF0FFF / 0x000F000F / 0x0FF00FF0.
// - Write to r0 (inc r0) -> wb_valid pulses, dbg_data(r0) stays 0; op 0111 -> illegal_op = 1,
//   no wb_valid; nop -> no wb_valid, ready stays 1.
// - Assert rst_n low during EXEC -> no wb_valid, all regs 0, FSM back in IDLE, ready = 1.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Issue unit that feeds one instruction at a time to an external combinational ALU:
// operands come from an internal register file and the result is written back.
module alu_issue_unit #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_ra,
  input  logic [REG_AW-1:0] instr_rb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal_op,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0]        OP_NOP = 4'b0000;
  localparam logic [REG_AW-1:0] R0     = {REG_AW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              start_s, bad_op_s;
  logic              ready_q, illegal_q, wb_valid_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rd_a_s, rd_b_s;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, wb_data_q;
  logic [3:0]        alu_op_q;
  logic [REG_AW-1:0] rd_q, wb_rd_q;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010, 4'b1011: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  // r0 is hard-wired to zero on every read port.
  assign rd_a_s   = (instr_ra == R0) ? {DATA_W{1'b0}} : regs_q[instr_ra];
  assign rd_b_s   = (instr_rb == R0) ? {DATA_W{1'b0}} : regs_q[instr_rb];
  assign dbg_data = (dbg_addr == R0) ? {DATA_W{1'b0}} : regs_q[dbg_addr];

  always_comb begin
    state_d  = state_q;
    start_s  = 1'b0;
    bad_op_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (!op_legal(instr_op)) begin
            bad_op_s = 1'b1;
          end else if (instr_op != OP_NOP) begin
            start_s = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      if (bad_op_s) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Operands are sampled at acceptance; the file cannot change before EXEC ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= {DATA_W{1'b0}};
      alu_b_q    <= {DATA_W{1'b0}};
      alu_op_q   <= 4'b0000;
      rd_q       <= R0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= R0;
      wb_data_q  <= {DATA_W{1'b0}};
    end else begin
      if (start_s) begin
        alu_a_q  <= rd_a_s;
        alu_b_q  <= rd_b_s;
        alu_op_q <= instr_op;
        rd_q     <= instr_rd;
      end else begin
        alu_a_q  <= {DATA_W{1'b0}};
        alu_b_q  <= {DATA_W{1'b0}};
        alu_op_q <= 4'b0000;
      end
      if (state_q == S_EXEC) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_q;
        wb_data_q  <= alu_res;
      end else begin
        wb_valid_q <= 1'b0;
        wb_rd_q    <= R0;
        wb_data_q  <= {DATA_W{1'b0}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if ((state_q == S_WB) && (wb_rd_q != R0)) begin
        regs_q[wb_rd_q] <= wb_data_q;
      end
    end
  end

  assign instr_ready = ready_q;
  assign illegal_op  = illegal_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural ALU on the alu_* ports.
module tb_alu_issue_unit;

  localparam logic [3:0] OP_NOP = 4'b0000, OP_INC = 4'b0010, OP_DEC = 4'b0011,
                         OP_ADD = 4'b0100, OP_SUB = 4'b0101, OP_OR  = 4'b1000,
                         OP_AND = 4'b1001, OP_XOR = 4'b1010, OP_NOT = 4'b1011,
                         OP_BAD = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd, instr_ra, instr_rb;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal_op;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  typedef struct packed {
    logic [2:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         exp_q[$];
  logic [31:0] ref_regs [8];
  int          pass_cnt = 0, total_cnt = 0, wb_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_W(32), .NREGS(8), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal_op(illegal_op), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      OP_INC:  alu_model = a + 32'd1;
      OP_DEC:  alu_model = a - 32'd1;
      OP_ADD:  alu_model = a + b;
      OP_SUB:  alu_model = a - b;
      OP_OR:   alu_model = a | b;
      OP_AND:  alu_model = a & b;
      OP_XOR:  alu_model = a ^ b;
      OP_NOT:  alu_model = ~a;
      default: alu_model = 32'd0;
    endcase
  endfunction

  always_comb alu_res = alu_model(alu_op, alu_a, alu_b);

  // Every write-back pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      wb_t e;
      wb_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_unexpected: got rd=%0d data=%h, none expected", wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data)
          $display("FAIL wb_data: got rd=%0d data=%h, want rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        else pass_cnt++;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) ref_regs[i] = 32'd0;
    exp_q.delete();
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb);
    int n;
    logic [31:0] a, b, r;
    logic runs;
    wb_t e;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (!instr_ready) $display("FAIL issue_timeout: ready=%b after %0d cycles, want 1", instr_ready, n);
    else pass_cnt++;
    a    = (ra == 3'd0) ? 32'd0 : ref_regs[ra];
    b    = (rb == 3'd0) ? 32'd0 : ref_regs[rb];
    r    = alu_model(op, a, b);
    runs = (op == OP_INC || op == OP_DEC || op == OP_ADD || op == OP_SUB ||
            op == OP_OR  || op == OP_AND || op == OP_XOR || op == OP_NOT);
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    instr_valid = 1'b1;
    if (runs) begin
      e.rd = rd;
      e.data = r;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    if (runs) begin
      total_cnt++;
      if (instr_ready !== 1'b0 || alu_op !== op || alu_a !== a || alu_b !== b)
        $display("FAIL exec_drive: ready=%b op=%h a=%h b=%h, want ready=0 op=%h a=%h b=%h",
                 instr_ready, alu_op, alu_a, alu_b, op, a, b);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (instr_ready !== 1'b0 || alu_op !== 4'b0000 || wb_valid !== 1'b1)
        $display("FAIL wb_phase: ready=%b op=%h wb_valid=%b, want 0/0/1",
                 instr_ready, alu_op, wb_valid);
      else pass_cnt++;
      @(posedge clk);
      #1;
      if (rd != 3'd0) ref_regs[rd] = r;
    end
    total_cnt++;
    if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || alu_op !== 4'b0000)
      $display("FAIL back_idle: ready=%b wb_valid=%b op=%h, want 1/0/0",
               instr_ready, wb_valid, alu_op);
    else pass_cnt++;
  endtask

  task automatic load_const(input logic [2:0] rd, input logic [31:0] v);
    logic started;
    started = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (started) issue(OP_ADD, rd, rd, rd);
      if (v[i]) begin
        issue(OP_INC, rd, rd, rd);
        started = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total_cnt++;
    if (instr_ready !== 1'b1 || illegal_op !== 1'b0 || wb_valid !== 1'b0 || alu_op !== 4'b0000)
      $display("FAIL reset_outputs: ready=%b illegal=%b wb_valid=%b op=%h, want 1/0/0/0",
               instr_ready, illegal_op, wb_valid, alu_op);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== 32'd0) $display("FAIL reset_reg r%0d: got %h, want 0", i, dbg_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_inc_add();
    int w0;
    logic [31:0] want [8];
    apply_reset();
    w0 = wb_cnt;
    repeat (3) issue(OP_INC, 3'd1, 3'd1, 3'd0);
    issue(OP_ADD, 3'd2, 3'd1, 3'd1);
    total_cnt++;
    if (wb_cnt - w0 != 4) $display("FAIL inc_add_pulses: got %0d, want 4", wb_cnt - w0);
    else pass_cnt++;
    want = '{32'd0, 32'd3, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 3; i++) begin
      dbg_addr = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== want[i]) $display("FAIL inc_add r%0d: got %h, want %h", i, dbg_data, want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [8];
    apply_reset();
    issue(OP_DEC, 3'd3, 3'd3, 3'd0);
    issue(OP_SUB, 3'd4, 3'd0, 3'd1);
    issue(OP_NOT, 3'd5, 3'd0, 3'd0);
    want = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    for (int i = 3; i < 6; i++) begin
      dbg_addr = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== want[i]) $display("FAIL wrap r%0d: got %h, want %h", i, dbg_data, want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_logic();
    logic [31:0] want [8];
    apply_reset();
    load_const(3'd1, 32'h0F0F_0F0F);
    load_const(3'd2, 32'h00FF_00FF);
    issue(OP_OR,  3'd3, 3'd1, 3'd2);
    issue(OP_AND, 3'd4, 3'd1, 3'd2);
    issue(OP_XOR, 3'd6, 3'd1, 3'd2);
    want = '{32'd0, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FFF_0FFF, 32'h000F_000F,
             32'd0, 32'h0FF0_0FF0, 32'd0};
    for (int i = 1; i < 7; i++) begin
      dbg_addr = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== want[i]) $display("FAIL logic r%0d: got %h, want %h", i, dbg_data, want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_r0_illegal_nop();
    int w0;
    apply_reset();
    w0 = wb_cnt;
    issue(OP_INC, 3'd0, 3'd0, 3'd0);
    dbg_addr = 3'd0;
    #1;
    total_cnt++;
    if (wb_cnt - w0 != 1 || dbg_data !== 32'd0)
      $display("FAIL r0_write: pulses=%0d r0=%h, want 1 and 0", wb_cnt - w0, dbg_data);
    else pass_cnt++;
    w0 = wb_cnt;
    issue(OP_BAD, 3'd1, 3'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (illegal_op !== 1'b1 || wb_cnt != w0)
      $display("FAIL illegal: illegal_op=%b pulses=%0d, want 1 and 0", illegal_op, wb_cnt - w0);
    else pass_cnt++;
    issue(OP_NOP, 3'd2, 3'd0, 3'd0);
    issue(OP_INC, 3'd2, 3'd2, 3'd0);
    dbg_addr = 3'd2;
    #1;
    total_cnt++;
    if (wb_cnt - w0 != 1 || illegal_op !== 1'b1 || dbg_data !== 32'd1)
      $display("FAIL nop_sticky: pulses=%0d illegal=%b r2=%h, want 1/1/1",
               wb_cnt - w0, illegal_op, dbg_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_exec();
    int w0;
    apply_reset();
    issue(OP_INC, 3'd1, 3'd1, 3'd0);
    dbg_addr = 3'd1;
    #1;
    total_cnt++;
    if (dbg_data !== 32'd1) $display("FAIL pre_reset r1: got %h, want 1", dbg_data);
    else pass_cnt++;
    @(negedge clk);
    instr_op = OP_INC; instr_rd = 3'd2; instr_ra = 3'd1; instr_rb = 3'd0;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    total_cnt++;
    if (alu_op !== OP_INC || alu_a !== 32'd1)
      $display("FAIL mid_exec: op=%h a=%h, want %h and 1", alu_op, alu_a, OP_INC);
    else pass_cnt++;
    w0 = wb_cnt;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (wb_valid !== 1'b0 || instr_ready !== 1'b1 || alu_op !== 4'b0000 || alu_a !== 32'd0)
      $display("FAIL async_reset: wb_valid=%b ready=%b op=%h a=%h, want 0/1/0/0",
               wb_valid, instr_ready, alu_op, alu_a);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) ref_regs[i] = 32'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== 32'd0) $display("FAIL post_reset r%0d: got %h, want 0", i, dbg_data);
      else pass_cnt++;
    end
    total_cnt++;
    if (wb_cnt != w0 || instr_ready !== 1'b1)
      $display("FAIL dropped_instr: pulses=%0d ready=%b, want 0 and 1", wb_cnt - w0, instr_ready);
    else pass_cnt++;
    issue(OP_INC, 3'd2, 3'd2, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr_op = 4'b0000; instr_rd = 3'd0; instr_ra = 3'd0; instr_rb = 3'd0;
    dbg_addr = 3'd0;
    test_reset();
    test_inc_add();
    test_wrap();
    test_logic();
    test_r0_illegal_nop();
    test_reset_exec();
    repeat (2) @(negedge clk);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
